// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the oversampling UART receiver.
//   rx_state_e           - receiver FSM state encoding
//   DATA_BITS            - data bits per frame (8N1)
//   DEFAULT_CLKS_PER_BIT - default bit period in clocks (10 MHz / 115200)
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 87;

  typedef enum logic [2:0] {
    StWaitHigh,
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchronizer for a single asynchronous bit.
//   clk - sampling clock
//   rst - asynchronous active-high reset; both flops load RESET_VAL
//   d   - asynchronous input
//   q   - synchronized output, 2 cycles of latency
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling 8N1 UART receiver with 3-sample majority voting,
// framing/break detection and a one-entry valid/ready holding register.
//   i_Clock     - clock, rising edge
//   i_Reset     - asynchronous active-high reset
//   i_Rx_Serial - asynchronous serial line, idle high
//   o_Rx_DV     - holding register valid
//   o_Rx_Byte   - holding register data, stable while o_Rx_DV
//   i_Rx_Ready  - consumer accepts the byte when o_Rx_DV & i_Rx_Ready
//   o_Frame_Err - 1-cycle pulse: stop bit sampled low, byte discarded
//   o_Break     - 1-cycle pulse with o_Frame_Err when the whole frame was low
//   o_Overrun   - 1-cycle pulse: good byte dropped, holding register full
//   o_Rx_Busy   - receiver is inside a frame (START/DATA/STOP)
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  input  logic                 i_Rx_Ready,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Overrun,
  output logic                 o_Rx_Busy
);

  localparam int unsigned M  = (CLKS_PER_BIT - 1) / 2;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CntLast = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CntS0   = CW'(M - 1);
  localparam logic [CW-1:0] CntS1   = CW'(M);
  localparam logic [CW-1:0] CntDec  = CW'(M + 1);
  localparam logic [IW-1:0] IdxLast = IW'(DATA_BITS - 1);

  logic rx_s;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (i_Clock),
    .rst (i_Reset),
    .d   (i_Rx_Serial),
    .q   (rx_s)
  );

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 s0_q, s0_d;
  logic                 s1_q, s1_d;
  logic [1:0]           prime_q;
  logic                 rx_dv_q, rx_dv_d;
  logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
  logic                 frame_err_q, frame_err_d;
  logic                 break_q, break_d;
  logic                 overrun_q, overrun_d;

  logic busy;
  logic primed;
  logic at_last;
  logic at_dec;
  logic majority;
  logic deliver;
  logic take;

  // rx_s holds the synchronizer reset value for two cycles after reset; it
  // must not be mistaken for an idle line when reset drops mid-frame.
  assign primed   = prime_q[1];
  assign busy     = (state_q == StStart) || (state_q == StData) || (state_q == StStop);
  assign at_last  = (cnt_q == CntLast);
  assign at_dec   = (cnt_q == CntDec);
  // Third sample is the live line at the decision count.
  assign majority = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
  assign take     = rx_dv_q & i_Rx_Ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
    frame_err_d = 1'b0;
    break_d     = 1'b0;
    deliver     = 1'b0;

    if (busy) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
      if (cnt_q == CntS0) s0_d = rx_s;
      if (cnt_q == CntS1) s1_d = rx_s;
    end

    unique case (state_q)
      StWaitHigh: begin
        cnt_d = '0;
        if (primed && rx_s) state_d = StIdle;
      end
      StIdle: begin
        cnt_d = '0;
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        if (at_dec && majority) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (at_last) begin
          state_d = StData;
          idx_d   = '0;
        end
      end
      StData: begin
        if (at_dec) shift_d[idx_q] = majority;
        if (at_last) begin
          if (idx_q == IdxLast) state_d = StStop;
          else                  idx_d   = idx_q + 1'b1;
        end
      end
      StStop: begin
        // Decide half a bit early so the next start edge is not missed.
        if (at_dec) begin
          cnt_d = '0;
          if (majority) begin
            deliver = 1'b1;
            state_d = StIdle;
          end else begin
            frame_err_d = 1'b1;
            break_d     = (shift_q == '0);
            state_d     = StWaitHigh;
          end
        end
      end
      default: begin
        state_d = StWaitHigh;
        cnt_d   = '0;
      end
    endcase
  end

  // Holding register: a transfer and a new load on the same edge keep DV high.
  always_comb begin
    rx_dv_d   = rx_dv_q & ~take;
    rx_byte_d = rx_byte_q;
    overrun_d = 1'b0;
    if (deliver) begin
      if (!rx_dv_q || take) begin
        rx_dv_d   = 1'b1;
        rx_byte_d = shift_q;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q     <= StWaitHigh;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      s0_q        <= 1'b0;
      s1_q        <= 1'b0;
      prime_q     <= 2'b00;
      rx_dv_q     <= 1'b0;
      rx_byte_q   <= '0;
      frame_err_q <= 1'b0;
      break_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      prime_q     <= {prime_q[0], 1'b1};
      rx_dv_q     <= rx_dv_d;
      rx_byte_q   <= rx_byte_d;
      frame_err_q <= frame_err_d;
      break_q     <= break_d;
      overrun_q   <= overrun_d;
    end
  end

  assign o_Rx_DV     = rx_dv_q;
  assign o_Rx_Byte   = rx_byte_q;
  assign o_Frame_Err = frame_err_q;
  assign o_Break     = break_q;
  assign o_Overrun   = overrun_q;
  assign o_Rx_Busy   = busy;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: scoreboard bench for uart_rx_os. Stimulus pushes expected
// events into a queue; a negedge monitor pops and compares on every transfer
// or pulse the DUT presents.
module tb_uart_rx_os;

  localparam int CPB  = 87;
  localparam int M_TB = (CPB - 1) / 2;

  typedef enum int {EvByte, EvFrame, EvBreak, EvOverrun} ev_e;
  typedef struct {
    ev_e        kind;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic       dv;
  logic [7:0] rx_byte;
  logic       frame_err;
  logic       brk;
  logic       overrun;
  logic       busy;

  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];

  uart_rx_os #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Rx_Serial (rx),
    .o_Rx_DV     (dv),
    .o_Rx_Byte   (rx_byte),
    .i_Rx_Ready  (ready),
    .o_Frame_Err (frame_err),
    .o_Break     (brk),
    .o_Overrun   (overrun),
    .o_Rx_Busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic push(input ev_e kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic ev_check(input ev_e kind, input logic [7:0] data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d data=%02h, expected none", kind, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == EvByte && e.data !== data)) begin
        errors++;
        $display("FAIL event: got kind=%0d data=%02h, expected kind=%0d data=%02h",
                 kind, data, e.kind, e.data);
      end
    end
  endtask

  // Monitor: inputs change 1 time unit after posedge, so negedge sees stable
  // values for the edge to come.
  always @(negedge clk) begin
    if (!rst) begin
      if (brk && !frame_err) begin
        checks++;
        errors++;
        $display("FAIL break_alone: got break=1 frame_err=0, expected frame_err=1");
      end
      if (frame_err) ev_check(frame_err && brk ? EvBreak : EvFrame, 8'h00);
      if (overrun)   ev_check(EvOverrun, 8'h00);
      if (dv && ready) ev_check(EvByte, rx_byte);
    end
  end

  task automatic line(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 rx = v;
    end
  endtask

  // One 8N1 frame; spike inverts one cycle near mid-bit of every bit.
  task automatic send_byte(input logic [7:0] b, input int cpb, input logic stop_v,
                           input bit spike);
    logic [9:0] bits;
    bits = {stop_v, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < cpb; c++) begin
        @(posedge clk);
        #1 rx = (spike && c == M_TB + 1) ? ~bits[i] : bits[i];
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] stream [3];
    int         rates  [2];
    stream[0] = 8'h55;
    stream[1] = 8'hFF;
    stream[2] = 8'h00;
    rates[0]  = CPB - 2;
    rates[1]  = CPB + 2;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_dv", {31'd0, dv}, 32'd0);
    chk("reset_byte", {24'd0, rx_byte}, 32'h00);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset_break", {31'd0, brk}, 32'd0);
    chk("reset_overrun", {31'd0, overrun}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    line(1'b1, 10);

    // Clean byte
    ready = 1'b1;
    push(EvByte, 8'hA5);
    send_byte(8'hA5, CPB, 1'b1, 1'b0);
    line(1'b1, 20);

    // Short low glitch is rejected at the start-bit decision
    line(1'b0, 20);
    line(1'b1, 200);
    @(negedge clk);
    chk("glitch_busy", {31'd0, busy}, 32'd0);

    // Single-cycle spikes at mid-bit are outvoted
    push(EvByte, 8'h3C);
    send_byte(8'h3C, CPB, 1'b1, 1'b1);
    line(1'b1, 20);

    // Framing error
    push(EvFrame, 8'h00);
    send_byte(8'h41, CPB, 1'b0, 1'b0);
    line(1'b1, 100);
    @(negedge clk);
    chk("frame_dv", {31'd0, dv}, 32'd0);

    // Break, then a clean frame once the line has recovered
    push(EvBreak, 8'h00);
    line(1'b0, 12 * CPB);
    line(1'b1, 100);
    push(EvByte, 8'h5A);
    send_byte(8'h5A, CPB, 1'b1, 1'b0);
    line(1'b1, 20);

    // Overrun: 0x11 held, 0x22 dropped
    ready = 1'b0;
    push(EvOverrun, 8'h00);
    push(EvByte, 8'h11);
    send_byte(8'h11, CPB, 1'b1, 1'b0);
    line(1'b1, 10);
    send_byte(8'h22, CPB, 1'b1, 1'b0);
    line(1'b1, 20);
    @(negedge clk);
    chk("overrun_dv", {31'd0, dv}, 32'd1);
    chk("overrun_held", {24'd0, rx_byte}, 32'h11);
    @(posedge clk);
    #1 ready = 1'b1;
    line(1'b1, 10);

    // Consumer transfer on the very stop-decision edge of the next byte.
    // Decision edge: 2 sync + 1 detect + 9 bits + M+2 cycles after line drop.
    ready = 1'b0;
    push(EvByte, 8'h66);
    push(EvByte, 8'h22);
    send_byte(8'h66, CPB, 1'b1, 1'b0);
    line(1'b1, 10);
    fork
      send_byte(8'h22, CPB, 1'b1, 1'b0);
      begin
        repeat (9 * CPB + M_TB + 5) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
        @(negedge clk);
        chk("simul_dv", {31'd0, dv}, 32'd1);
        chk("simul_byte", {24'd0, rx_byte}, 32'h22);
      end
    join
    line(1'b1, 10);
    ready = 1'b1;
    line(1'b1, 10);

    // Baud tolerance, back-to-back frames
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) push(EvByte, stream[k]);
      for (int k = 0; k < 3; k++) send_byte(stream[k], rates[r], 1'b1, 1'b0);
      line(1'b1, 50);
    end

    // Reset during data bit 4 (low) of 0xE3; remaining bits are high
    fork
      send_byte(8'hE3, CPB, 1'b1, 1'b0);
      begin
        repeat (450) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midreset_dv", {31'd0, dv}, 32'd0);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
      end
    join
    line(1'b1, 50);
    push(EvByte, 8'h7E);
    send_byte(8'h7E, CPB, 1'b1, 1'b0);
    line(1'b1, 200);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
